// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_fifo.sv
// fetch_skid_fifo: 2-entry shift FIFO of fetch entries; entry 0 is always the head.
module fetch_skid_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t r_mem0;
  fetch_entry_t r_mem1;
  logic [1:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_mem0  <= wdata;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_mem1  <= wdata;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count != 2'd0) begin
            r_mem0  <= r_mem1;
            r_count <= r_count - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps the occupancy; the new word lands behind the survivor.
          if (r_count == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= wdata;
          end else begin
            r_mem0  <= wdata;
            r_count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = r_mem0;
  assign count = r_count;
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch: owns the fetch PC, issues 1-cycle-latency imem reads,
// buffers responses in a skid FIFO and squashes wrong-path words on redirect.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  logic [31:0]  r_fpc;
  logic         r_inflight;
  logic [31:0]  r_req_pc;

  logic         w_pop;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  logic [2:0]   w_occ;
  logic [31:0]  w_redirect_addr;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  assign w_pop           = if_valid && if_ready;
  assign w_redirect_addr = align_word(redirect_pc);
  // Buffered plus in-flight words after this cycle's pop; a new request fits only below 2.
  assign w_occ           = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_push          = r_inflight && !redirect && !w_full;
  assign w_wdata         = '{instr: imem_data, pc: r_req_pc};

  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = r_fpc;
    if (!rst) begin
      if (redirect) begin
        imem_rd   = 1'b1;
        imem_addr = w_redirect_addr;
      end else begin
        imem_rd = (w_occ < 3'd2);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc      <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_pc   <= RESET_PC;
    end else begin
      r_inflight <= imem_rd;
      if (imem_rd) begin
        r_fpc    <= imem_addr + PC_INC;
        r_req_pc <= imem_addr;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .wdata (w_wdata),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign if_valid    = !w_empty;
  assign if_instr    = w_head.instr;
  assign if_pc       = w_head.pc;
  assign if_pc_plus4 = w_head.pc + PC_INC;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage; memory returns each word equal to its address.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        erd;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tv[16];

  mips_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem_rd ? imem_addr : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!rst && dut.r_inflight && !redirect && dut.w_full) begin
      errors++;
      $display("FAIL fifo_push_full actual count=%0d required push only below 2", dut.w_count);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input logic ready, input logic redir, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc,
                               input logic erd, input logic [31:0] eaddr);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.erd = erd; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, id, act, exp);
    end
  endtask

  task automatic apply(input int id, input vec_t v);
    @(negedge clk);
    if_ready    = v.ready;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    #1;
    check("if_valid", id, {31'b0, if_valid}, {31'b0, v.ev});
    check("imem_rd", id, {31'b0, imem_rd}, {31'b0, v.erd});
    if (v.ev) begin
      check("if_pc", id, if_pc, v.epc);
      check("if_instr", id, if_instr, v.epc);
      check("if_pc_plus4", id, if_pc_plus4, v.epc + 32'd4);
    end
    if (v.erd) check("imem_addr", id, imem_addr, v.eaddr);
  endtask

  initial begin
    // reset release, stall with saturation, redirect with a full FIFO
    tv[0]  = mkv(1, 0, 0,     0, 0,     1, 32'h0);
    tv[1]  = mkv(1, 0, 0,     0, 0,     1, 32'h4);
    tv[2]  = mkv(0, 0, 0,     1, 32'h0, 0, 0);
    tv[3]  = mkv(0, 0, 0,     1, 32'h0, 0, 0);
    tv[4]  = mkv(0, 0, 0,     1, 32'h0, 0, 0);
    tv[5]  = mkv(0, 0, 0,     1, 32'h0, 0, 0);
    tv[6]  = mkv(0, 0, 0,     1, 32'h0, 0, 0);
    tv[7]  = mkv(1, 0, 0,     1, 32'h0, 1, 32'h8);
    tv[8]  = mkv(1, 0, 0,     1, 32'h4, 1, 32'hC);
    tv[9]  = mkv(1, 0, 0,     1, 32'h8, 1, 32'h10);
    tv[10] = mkv(1, 0, 0,     1, 32'hC, 1, 32'h14);
    tv[11] = mkv(0, 0, 0,     1, 32'h10, 0, 0);
    tv[12] = mkv(0, 1, 32'h103, 1, 32'h10, 1, 32'h100);
    tv[13] = mkv(1, 0, 0,     0, 0,     1, 32'h104);
    tv[14] = mkv(1, 0, 0,     1, 32'h100, 1, 32'h108);
    tv[15] = mkv(1, 0, 0,     1, 32'h104, 1, 32'h10C);

    #1;
    check("rst_if_valid", -1, {31'b0, if_valid}, 32'h0);
    check("rst_imem_rd", -1, {31'b0, imem_rd}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(i, tv[i]);

    // redirect in the same cycle as a pop; in-flight 0x10C must never appear
    apply(16, mkv(1, 1, 32'h200, 1, 32'h108, 1, 32'h200));
    apply(17, mkv(1, 0, 0,       0, 0,        1, 32'h204));
    apply(18, mkv(1, 0, 0,       1, 32'h200,  1, 32'h208));
    apply(19, mkv(1, 0, 0,       1, 32'h204,  1, 32'h20C));

    // redirect near the top of the address space: PC and PC+4 wrap
    apply(20, mkv(1, 1, 32'hFFFF_FFF8, 1, 32'h208,       1, 32'hFFFF_FFF8));
    apply(21, mkv(1, 0, 0,             0, 0,             1, 32'hFFFF_FFFC));
    apply(22, mkv(1, 0, 0,             1, 32'hFFFF_FFF8, 1, 32'h0));
    apply(23, mkv(1, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'h4));
    apply(24, mkv(1, 0, 0,             1, 32'h0,         1, 32'h8));

    // fill the FIFO, then reset mid-cycle
    apply(25, mkv(0, 0, 0, 1, 32'h4, 0, 0));
    apply(26, mkv(0, 0, 0, 1, 32'h4, 0, 0));
    check("pre_rst_count", 26, {30'b0, dut.w_count}, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("midrst_if_valid", 27, {31'b0, if_valid}, 32'h0);
    check("midrst_imem_rd", 27, {31'b0, imem_rd}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    apply(100, mkv(1, 0, 0, 0, 0,     1, 32'h0));
    apply(101, mkv(1, 0, 0, 0, 0,     1, 32'h4));
    apply(102, mkv(1, 0, 0, 1, 32'h0, 1, 32'h8));
    apply(103, mkv(1, 0, 0, 1, 32'h4, 1, 32'hC));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
